// File: rtl/mem_req_engine_if.sv
// mem_req_engine_if: FIFO, memory and response channels of the request engine.
// master = the engine, slave = the FIFO / memory / response consumer side.
interface mem_req_engine_if #(
   parameter int WIDTH  = 520,
   parameter int ADDR_W = 32
);
   // request FIFO side
   logic              fifo_empty;
   logic              fifo_rd;
   logic [WIDTH-1:0]  fifo_data;
   logic              memfin;
   // single-port memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [63:0]       mem_rdata;
   // response side
   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_data;
   logic [7:0]        rsp_op;
   logic              rsp_err;
   // status
   logic [7:0]        err_cnt;
   logic              busy;

   modport master (
      input  fifo_empty, fifo_data, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
      output fifo_rd, memfin, mem_req, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_data, rsp_op, rsp_err, err_cnt, busy
   );

   modport slave (
      output fifo_empty, fifo_data, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
      input  fifo_rd, memfin, mem_req, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_data, rsp_op, rsp_err, err_cnt, busy
   );
endinterface

// File: rtl/mem_req_engine.sv
// mem_req_engine: consumer of the 520-bit memory request FIFO. Pops one entry,
// decodes {op, addr, rsvd, wdata}, runs it on a single-port memory, returns the
// result on a valid/ready channel and pulses memfin so the FIFO retires the entry.
// Build macro MEM_REQ_TIMEOUT_EN adds a watchdog on the memory handshake; without
// it ISSUE/RWAIT wait indefinitely and TIMEOUT is ignored.
module mem_req_engine #(
   parameter int         WIDTH   = 520,
   parameter int         ADDR_W  = 32,
   parameter logic [7:0] OP_WR   = 8'h66,
   parameter logic [7:0] OP_RD   = 8'h55,
   parameter int         TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   mem_req_engine_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      CAP   = 3'd2,
      ISSUE = 3'd3,
      RWAIT = 3'd4,
      RESP  = 3'd5,
      FIN   = 3'd6
   } state_t;

   // decoded request; only the low ADDR_W address bits reach the memory
   typedef struct packed {
      logic [7:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [63:0]       wdata;
   } req_t;

   state_t      state;
   req_t        head;
   req_t        req_q;
   logic        head_ok;
   logic        fifo_rd_q;
   logic        memfin_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [63:0] rsp_data_q;
   logic [7:0]  err_cnt_q;
   logic        wdog_hit;

   // entry layout: op at the top byte, address field right below it, wdata at the bottom
   assign head = {bus.fifo_data[WIDTH-1 -: 8],
                  bus.fifo_data[WIDTH-72 +: ADDR_W],
                  bus.fifo_data[63:0]};
   assign head_ok = (head.op == OP_WR) || (head.op == OP_RD);

   // reserved bits and the upper address bits are intentionally ignored
   logic unused_fifo_bits;
   assign unused_fifo_bits = ^bus.fifo_data;

`ifdef MEM_REQ_TIMEOUT_EN
   logic [7:0] wdog;

   assign wdog_hit = (wdog == 8'(TIMEOUT - 1));

   // watchdog: cleared while capturing, counts every ISSUE/RWAIT cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wdog <= '0;
      else if (state == CAP)
         wdog <= '0;
      else if ((state == ISSUE || state == RWAIT) && !wdog_hit)
         wdog <= wdog + 8'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign wdog_hit = 1'b0;
`endif

   // request sequencer: one entry in flight, all outputs registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         req_q       <= '0;
         fifo_rd_q   <= 1'b0;
         memfin_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         // strobes are single-cycle unless a state re-asserts them
         fifo_rd_q <= 1'b0;
         memfin_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.fifo_empty) begin
                  fifo_rd_q <= 1'b1;
                  state     <= POP;
               end
            end
            // FIFO presents the head entry on the edge that ends POP
            POP: state <= CAP;
            CAP: begin
               req_q <= head;
               if (head_ok) begin
                  mem_req_q <= 1'b1;
                  mem_we_q  <= (head.op == OP_WR);
                  state     <= ISSUE;
               end else begin
                  // unknown opcode: answer with an error, never touch memory
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state       <= RESP;
               end
            end
            ISSUE: begin
               // rvalid alongside a read grant is not looked at here
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  if (mem_we_q) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= '0;
                     state       <= RESP;
                  end else begin
                     state <= RWAIT;
                  end
               end else if (wdog_hit) begin
                  mem_req_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state       <= RESP;
               end
            end
            RWAIT: begin
               if (bus.mem_rvalid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= bus.mem_rdata;
                  state       <= RESP;
               end else if (wdog_hit) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  memfin_q    <= 1'b1;
                  state       <= FIN;
               end
            end
            FIN: begin
               if (rsp_err_q && (err_cnt_q != 8'hFF))
                  err_cnt_q <= err_cnt_q + 8'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.fifo_rd   = fifo_rd_q;
   assign bus.memfin    = memfin_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = req_q.addr;
   assign bus.mem_wdata = req_q.wdata;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_op    = req_q.op;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.busy      = (state != IDLE);

   // handshake invariants of the two outbound channels
   a_fifo_rd_pulse: assert property (@(posedge clk) disable iff (!reset)
      bus.fifo_rd |=> !bus.fifo_rd);
   a_memfin_pulse: assert property (@(posedge clk) disable iff (!reset)
      bus.memfin |=> !bus.memfin);
   a_req_held: assert property (@(posedge clk) disable iff (!reset)
      (bus.mem_req && !bus.mem_gnt && !wdog_hit) |=> bus.mem_req);
   a_rsp_held: assert property (@(posedge clk) disable iff (!reset)
      (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_data)));

endmodule

// File: tb/tb_mem_req_engine.sv
// tb_mem_req_engine: directed tests with a response/memory scoreboard and a
// behavioural FIFO + memory around mem_req_engine.
module tb_mem_req_engine;
   localparam int WIDTH  = 520;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_req_engine_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) sif ();
   mem_req_engine #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(sif));

   typedef struct {
      logic [63:0] data;
      logic [7:0]  op;
      logic        err;
   } rsp_t;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
   } mreq_t;

   rsp_t             rsp_q[$];
   mreq_t            mem_q[$];
   logic [WIDTH-1:0] fq[$];

   int checks = 0;
   int failures = 0;
   int fin_cnt = 0;
   int rd_cnt = 0;
   int mem_hs_cnt = 0;
   int cyc = 0;
   int last_rd_cyc = 0;
   int last_lat = 0;

   // memory model knobs
   int          gnt_dly = 0;
   int          rv_dly = 1;
   bit          no_gnt = 0;
   bit          spur_rv = 0;
   logic [63:0] rd_data = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] mk(input logic [7:0] op, input logic [63:0] addr,
                                           input logic [63:0] wd);
      logic [383:0] rsvd;
      rsvd = {12{32'hCAFE_F00D}};
      return {op, addr, rsvd, wd};
   endfunction

   task automatic wait_fin(input string nm, input int target, input int budget);
      int n;
      n = 0;
      while (fin_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(fin_cnt >= target), 64'd1);
   endtask

   // FIFO model: head appears after fifo_rd, entry retired on memfin
   initial begin : fifo_model
      bit rd_s;
      bit fin_s;
      sif.fifo_empty = 1'b1;
      sif.fifo_data  = '0;
      forever begin
         @(negedge clk);
         rd_s  = sif.fifo_rd;
         fin_s = sif.memfin;
         @(posedge clk);
         #1;
         if (fin_s && fq.size() > 0) void'(fq.pop_front());
         if (rd_s && fq.size() > 0) sif.fifo_data = fq[0];
         sif.fifo_empty = (fq.size() == 0);
      end
   end

   // memory model: grant after gnt_dly request cycles, read data rv_dly cycles after grant
   initial begin : mem_model
      int wait_c;
      int rv_c;
      bit rd_pend;
      wait_c = 0;
      rv_c = 0;
      rd_pend = 0;
      sif.mem_gnt = 1'b0;
      sif.mem_rvalid = 1'b0;
      sif.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         sif.mem_gnt = 1'b0;
         sif.mem_rvalid = 1'b0;
         if (!reset) begin
            rd_pend = 0;
            wait_c = 0;
         end else if (rd_pend) begin
            if (rv_c == 0) begin
               sif.mem_rvalid = 1'b1;
               sif.mem_rdata = rd_data;
               rd_pend = 0;
            end else begin
               rv_c--;
            end
         end else if (sif.mem_req && !no_gnt) begin
            if (wait_c == gnt_dly) begin
               sif.mem_gnt = 1'b1;
               wait_c = 0;
               if (!sif.mem_we) begin
                  rd_pend = 1;
                  rv_c = rv_dly - 1;
                  if (spur_rv) begin
                     sif.mem_rvalid = 1'b1;
                     sif.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                  end
               end
            end else begin
               wait_c++;
            end
         end
      end
   end

   // monitor: pops the scoreboards on each handshake and tracks the strobes
   initial begin : monitor
      bit    hs_prev;
      rsp_t  er;
      mreq_t em;
      hs_prev = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (sif.fifo_rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
         end
         if (hs_prev) chk("memfin_after_hs", 64'(sif.memfin), 64'd1);
         else if (sif.memfin) chk("memfin_spurious", 64'(sif.memfin), 64'd0);
         if (sif.memfin) begin
            fin_cnt++;
            last_lat = cyc - last_rd_cyc;
         end
         hs_prev = sif.rsp_valid && sif.rsp_ready && reset;
         if (hs_prev) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(sif.rsp_valid), 64'd0);
            end else begin
               er = rsp_q.pop_front();
               chk("rsp_data", sif.rsp_data, er.data);
               chk("rsp_op", 64'(sif.rsp_op), 64'(er.op));
               chk("rsp_err", 64'(sif.rsp_err), 64'(er.err));
            end
         end
         if (sif.mem_req && sif.mem_gnt) begin
            mem_hs_cnt++;
            if (mem_q.size() == 0) begin
               chk("mem_unexpected", 64'(sif.mem_req), 64'd0);
            end else begin
               em = mem_q.pop_front();
               chk("mem_we", 64'(sif.mem_we), 64'(em.we));
               chk("mem_addr", 64'(sif.mem_addr), 64'(em.addr));
               if (em.we) chk("mem_wdata", sif.mem_wdata, em.wdata);
            end
         end
      end
   end

   initial begin : stim
      int n;
      int base;
      sif.rsp_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_fifo_rd", 64'(sif.fifo_rd), 64'd0);
      chk("rst_memfin", 64'(sif.memfin), 64'd0);
      chk("rst_mem_req", 64'(sif.mem_req), 64'd0);
      chk("rst_rsp_valid", 64'(sif.rsp_valid), 64'd0);
      chk("rst_busy", 64'(sif.busy), 64'd0);
      chk("rst_err_cnt", 64'(sif.err_cnt), 64'd0);
      chk("rst_rsp_data", sif.rsp_data, 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // 1: write, granted on the first request cycle
      mem_q.push_back('{we: 1'b1, addr: 32'h1000, wdata: 64'hEEEE_EEEE_EEEE_EBBB});
      rsp_q.push_back('{data: 64'd0, op: 8'h66, err: 1'b0});
      fq.push_back(mk(8'h66, 64'h1000, 64'hEEEE_EEEE_EEEE_EBBB));
      wait_fin("t1_fin", 1, 60);
      chk("t1_latency", 64'(last_lat), 64'd4);
      chk("t1_fifo_rd_cnt", 64'(rd_cnt), 64'd1);

      // 2: read, rvalid 3 cycles after grant; a stray rvalid with the grant is ignored
      rv_dly = 3;
      rd_data = 64'hA5A5;
      spur_rv = 1;
      mem_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 64'd0});
      rsp_q.push_back('{data: 64'hA5A5, op: 8'h55, err: 1'b0});
      fq.push_back(mk(8'h55, 64'h20, 64'h0));
      wait_fin("t2_fin", 2, 60);
      spur_rv = 0;

      // 3: bad opcode, no memory access, error counted
      rsp_q.push_back('{data: 64'd0, op: 8'h00, err: 1'b1});
      fq.push_back(mk(8'h00, 64'h80, 64'h1234));
      wait_fin("t3_fin", 3, 60);
      repeat (2) @(negedge clk);
      chk("t3_err_cnt", 64'(sif.err_cnt), 64'd1);

      // 4: response backpressure for 10 cycles
      @(posedge clk);
      #1 sif.rsp_ready = 1'b0;
      rv_dly = 1;
      rd_data = 64'h0123_4567_89AB_CDEF;
      mem_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 64'd0});
      rsp_q.push_back('{data: 64'h0123_4567_89AB_CDEF, op: 8'h55, err: 1'b0});
      fq.push_back(mk(8'h55, 64'h44, 64'h0));
      n = 0;
      while (!sif.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_rsp_valid_seen", 64'(sif.rsp_valid), 64'd1);
      repeat (10) begin
         @(negedge clk);
         chk("t4_valid_held", 64'(sif.rsp_valid), 64'd1);
         chk("t4_data_held", sif.rsp_data, 64'h0123_4567_89AB_CDEF);
         chk("t4_no_memfin", 64'(sif.memfin), 64'd0);
      end
      @(posedge clk);
      #1 sif.rsp_ready = 1'b1;
      wait_fin("t4_fin", 4, 30);

      // 5: three back-to-back entries, then the FIFO runs empty
      rd_data = 64'h2222;
      mem_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 64'h11});
      rsp_q.push_back('{data: 64'd0, op: 8'h66, err: 1'b0});
      mem_q.push_back('{we: 1'b0, addr: 32'h50, wdata: 64'd0});
      rsp_q.push_back('{data: 64'h2222, op: 8'h55, err: 1'b0});
      rsp_q.push_back('{data: 64'd0, op: 8'h77, err: 1'b1});
      fq.push_back(mk(8'h66, 64'hFFFF_0000_0000_0040, 64'h11));
      fq.push_back(mk(8'h55, 64'h50, 64'h0));
      fq.push_back(mk(8'h77, 64'h60, 64'h0));
      wait_fin("t5_fin", 7, 150);
      repeat (3) @(negedge clk);
      chk("t5_busy_idle", 64'(sif.busy), 64'd0);
      chk("t5_fifo_rd_cnt", 64'(rd_cnt), 64'd7);
      chk("t5_err_cnt", 64'(sif.err_cnt), 64'd2);

      // 6: reset in RWAIT aborts; the same entry is popped and executed again
      rv_dly = 20;
      rd_data = 64'h1234_5678_9ABC_DEF0;
      mem_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 64'd0});
      mem_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 64'd0});
      rsp_q.push_back('{data: 64'h1234_5678_9ABC_DEF0, op: 8'h55, err: 1'b0});
      base = mem_hs_cnt;
      fq.push_back(mk(8'h55, 64'h300, 64'h0));
      n = 0;
      while (mem_hs_cnt == base && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_grant_seen", 64'(mem_hs_cnt), 64'(base + 1));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_mem_req", 64'(sif.mem_req), 64'd0);
      chk("t6_rst_rsp_valid", 64'(sif.rsp_valid), 64'd0);
      chk("t6_rst_memfin", 64'(sif.memfin), 64'd0);
      chk("t6_rst_busy", 64'(sif.busy), 64'd0);
      chk("t6_rst_err_cnt", 64'(sif.err_cnt), 64'd0);
      rv_dly = 2;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      wait_fin("t6_fin", 8, 100);
      chk("t6_fifo_rd_cnt", 64'(rd_cnt), 64'd9);

`ifdef MEM_REQ_TIMEOUT_EN
      // 7: grant never comes; watchdog answers with an error
      no_gnt = 1;
      rsp_q.push_back('{data: 64'd0, op: 8'h66, err: 1'b1});
      fq.push_back(mk(8'h66, 64'h400, 64'h55));
      wait_fin("t7_fin", 9, 200);
      chk("t7_latency", 64'(last_lat), 64'd67);
      repeat (2) @(negedge clk);
      chk("t7_err_cnt", 64'(sif.err_cnt), 64'd1);
      no_gnt = 0;
`endif

      repeat (3) @(negedge clk);
      chk("rsp_sb_drained", 64'(rsp_q.size()), 64'd0);
      chk("mem_sb_drained", 64'(mem_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
